// File: rtl/store_pkg.sv
// Shared store-path definitions: size codes, FSM encoding and request helpers.
// Also used by the load-side assembler.
package store_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEND   = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   // Number of memory beats a legal size code needs; 0 for the illegal code.
   function automatic logic [2:0] beats_for_size(input logic [1:0] size);
      case (size)
         SIZE_BYTE: beats_for_size = 3'd1;
         SIZE_HALF: beats_for_size = 3'd2;
         SIZE_WORD: beats_for_size = 3'd4;
         default:   beats_for_size = 3'd0;
      endcase
   endfunction

   // addr_lsbs[1] is the address LSB (big-endian bit numbering).
   function automatic logic misaligned(input logic [1:0] size, input logic [0:1] addr_lsbs);
      case (size)
         SIZE_HALF: misaligned = addr_lsbs[1];
         SIZE_WORD: misaligned = |addr_lsbs;
         default:   misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/store_lane_mux.sv
// Picks the register byte for a given beat of a narrowed store.
// Big-endian: beat 0 carries the most significant selected byte.
module store_lane_mux
   import store_pkg::*;
(
   input  logic [0:31] data,
   input  logic [1:0]  size,
   input  logic [0:1]  beat_idx,
   output logic [0:7]  lane_byte
);

   logic [1:0] lane;

   // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      lane = beat_idx;
      case (size)
         SIZE_BYTE: lane = 2'd3;
         SIZE_HALF: lane = {1'b1, beat_idx[1]};
         default:   lane = beat_idx;
      endcase

      case (lane)
         2'd0:    lane_byte = data[0:7];
         2'd1:    lane_byte = data[8:15];
         2'd2:    lane_byte = data[16:23];
         default: lane_byte = data[24:31];
      endcase
   end

endmodule

// File: rtl/store_narrow_serializer.sv
// Narrows a 32-bit store to byte/half/word and streams it one byte per beat
// onto a byte-wide memory port, with valid/ready on both sides.
module store_narrow_serializer
   import store_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [0:31]       req_data,
   input  logic [0:ADDR_W-1] req_addr,
   input  logic [1:0]        req_size,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [0:ADDR_W-1] mem_addr,
   output logic [0:7]        mem_byte,
   output logic              done,
   output logic              err
);

   logic [1:0]        state;
   logic [0:31]       data_q;
   logic [0:ADDR_W-1] addr_q;
   logic [1:0]        size_q;
   logic [0:1]        beat_idx;
   logic [0:1]        last_idx;
   logic              err_q;

   logic       req_bad;
   logic [2:0] beats_m1;

   assign req_bad  = (req_size == 2'b11) || misaligned(req_size, req_addr[ADDR_W-2:ADDR_W-1]);
   assign beats_m1 = beats_for_size(req_size) - 3'd1;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         data_q   <= '0;
         addr_q   <= '0;
         size_q   <= SIZE_BYTE;
         beat_idx <= '0;
         last_idx <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  data_q <= req_data;
                  addr_q <= req_addr;
                  size_q <= req_size;
                  if (req_bad) begin
                     err_q <= 1'b1;
                  end else begin
                     beat_idx <= '0;
                     last_idx <= beats_m1[1:0];
                     state    <= ST_SEND;
                  end
               end
            end
            ST_SEND: begin
               // mem_valid is high throughout SEND, so mem_ready alone completes a beat.
               if (mem_ready) begin
                  if (beat_idx == last_idx) state <= ST_FINISH;
                  else                      beat_idx <= beat_idx + 2'd1;
               end
            end
            ST_FINISH: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   store_lane_mux u_lane_mux (
      .data      (data_q),
      .size      (size_q),
      .beat_idx  (beat_idx),
      .lane_byte (mem_byte)
   );

   // Address arithmetic wraps naturally at 2^ADDR_W.
   assign mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, beat_idx};
   assign req_ready = (state == ST_IDLE);
   assign mem_valid = (state == ST_SEND);
   assign done      = (state == ST_FINISH);
   assign err       = err_q;

endmodule

// File: tb/tb_store_narrow_serializer.sv
// Directed self-checking bench for store_narrow_serializer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_store_narrow_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [0:31] req_data;
   logic [0:31] req_addr;
   logic [1:0]  req_size;
   logic        mem_valid;
   logic        mem_ready;
   logic [0:31] mem_addr;
   logic [0:7]  mem_byte;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_narrow_serializer #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_byte  (mem_byte),
      .done      (done),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Presents a request for one cycle; returns in the cycle after the accepting edge.
   task automatic send_req(input logic [31:0] data, input logic [31:0] addr, input logic [1:0] size);
      check("req_ready_before_req", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_data  = data;
      req_addr  = addr;
      req_size  = size;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic expect_beat(input string tag, input logic [31:0] addr, input logic [7:0] data);
      check({tag, "_valid"}, {31'd0, mem_valid}, 32'd1);
      check({tag, "_addr"}, mem_addr, addr);
      check({tag, "_byte"}, {24'd0, mem_byte}, {24'd0, data});
      check({tag, "_ready_low"}, {31'd0, req_ready}, 32'd0);
      check({tag, "_err"}, {31'd0, err}, 32'd0);
      @(negedge clk);
   endtask

   // FINISH cycle, then the IDLE cycle after it.
   task automatic expect_done(input string tag);
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_valid_low"}, {31'd0, mem_valid}, 32'd0);
      check({tag, "_ready_in_finish"}, {31'd0, req_ready}, 32'd0);
      check({tag, "_err_low"}, {31'd0, err}, 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
   endtask

   task automatic expect_err(input string tag);
      check({tag, "_err"}, {31'd0, err}, 32'd1);
      check({tag, "_no_beat"}, {31'd0, mem_valid}, 32'd0);
      check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_no_done"}, {31'd0, done}, 32'd0);
      @(negedge clk);
      check({tag, "_err_pulse"}, {31'd0, err}, 32'd0);
      check({tag, "_still_idle"}, {31'd0, mem_valid}, 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_data  = '0;
      req_addr  = '0;
      req_size  = 2'b00;
      mem_ready = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_valid", {31'd0, mem_valid}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_byte", {24'd0, mem_byte}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: word store, memory always ready
      mem_ready = 1'b1;
      send_req(32'hA1B2C3D4, 32'h100, 2'b10);
      expect_beat("w_b0", 32'h100, 8'hA1);
      expect_beat("w_b1", 32'h101, 8'hB2);
      expect_beat("w_b2", 32'h102, 8'hC3);
      expect_beat("w_b3", 32'h103, 8'hD4);
      expect_done("w");

      // 2: half store with three stalled cycles on beat 0
      mem_ready = 1'b0;
      send_req(32'h0000BEEF, 32'h22, 2'b01);
      expect_beat("h_stall0", 32'h22, 8'hBE);
      expect_beat("h_stall1", 32'h22, 8'hBE);
      expect_beat("h_stall2", 32'h22, 8'hBE);
      mem_ready = 1'b1;
      expect_beat("h_b0", 32'h22, 8'hBE);
      expect_beat("h_b1", 32'h23, 8'hEF);
      expect_done("h");

      // 3: byte store at odd address
      send_req(32'h12345678, 32'h7, 2'b00);
      expect_beat("b_b0", 32'h7, 8'h78);
      expect_done("b");

      // 4: rejected requests
      send_req(32'hDEADBEEF, 32'h102, 2'b10);
      expect_err("mis_word");
      send_req(32'hDEADBEEF, 32'h5, 2'b01);
      expect_err("mis_half");
      send_req(32'hDEADBEEF, 32'h0, 2'b11);
      expect_err("ill_size");

      // 5: reset during beat 2 of a word store
      send_req(32'h11223344, 32'h200, 2'b10);
      expect_beat("r_b0", 32'h200, 8'h11);
      expect_beat("r_b1", 32'h201, 8'h22);
      check("r_b2_addr", mem_addr, 32'h202);
      check("r_b2_byte", {24'd0, mem_byte}, 32'h33);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("r_abort_valid", {31'd0, mem_valid}, 32'd0);
      check("r_abort_done", {31'd0, done}, 32'd0);
      check("r_abort_ready", {31'd0, req_ready}, 32'd1);
      check("r_abort_addr", mem_addr, 32'd0);
      @(negedge clk);
      check("r_abort_stays_idle", {31'd0, mem_valid}, 32'd0);
      send_req(32'h000000AB, 32'h40, 2'b00);
      expect_beat("r_new_b0", 32'h40, 8'hAB);
      expect_done("r_new");

      // 6: address wrap at top of memory
      send_req(32'h01020304, 32'hFFFFFFFC, 2'b10);
      expect_beat("wrap_b0", 32'hFFFFFFFC, 8'h01);
      expect_beat("wrap_b1", 32'hFFFFFFFD, 8'h02);
      expect_beat("wrap_b2", 32'hFFFFFFFE, 8'h03);
      expect_beat("wrap_b3", 32'hFFFFFFFF, 8'h04);
      expect_done("wrap");
      send_req(32'h00000055, 32'h0, 2'b00);
      expect_beat("zero_b0", 32'h0, 8'h55);
      expect_done("zero");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/store_narrow_serializer.md
Name: store_narrow_serializer

Overview:
- Memory-side store unit that narrows a 32-bit register value to the byte, halfword or word selected by the store opcode.
- Streams the selected bytes, one per beat, onto an 8-bit memory write port.
- Is the narrowing counterpart of the immediate/load widening path in the datapath.
- Sits between the execute stage's store request and the byte-wide data memory; stalls the requester via a valid/ready handshake.

Parameters:
ADDR_W, 32, width of request and memory byte address
SIZE_BYTE, 2'b00, req_size code for a 1-byte store
SIZE_HALF, 2'b01, req_size code for a 2-byte store
SIZE_WORD, 2'b10, req_size code for a 4-byte store (2'b11 is illegal)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, synchronous, active-low
req_valid  input  1  store request present
req_ready  output  1  unit can accept a request
req_data  input  [0:31]  register value; bit 0 is MSB
req_addr  input  [0:ADDR_W-1]  byte address; bit ADDR_W-1 is LSB
req_size  input  2  size code
mem_valid  output  1  memory beat valid
mem_ready  input  1  memory accepts beat
mem_addr  output  [0:ADDR_W-1]  byte address of current beat
mem_byte  output  [0:7]  data byte of current beat
done  output  1  one-cycle pulse: store completed
err  output  1  one-cycle pulse: request rejected (misaligned or illegal size)

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - req_ready=1; mem_valid=0, done=0, err=0.
  - mem_addr=0, mem_byte=0.
  - Reset mid-store aborts immediately; no further beats are issued.
- States: IDLE, SEND, FINISH.
- IDLE:
  - req_ready=1.
  - Accept when req_valid=1.
  - On accept, capture data, addr and size, then check the request:
    - illegal if size=2'b11;
    - misaligned if size=HALF and addr LSB=1;
    - misaligned if size=WORD and addr[ADDR_W-2:ADDR_W-1]!=0.
  - Illegal or misaligned: err=1 for the next cycle, stay in IDLE, issue no memory beat.
  - Otherwise: load beat count (BYTE=1, HALF=2, WORD=4) and go to SEND.
- Byte selection is big-endian; the lowest address gets the most significant selected byte:
  - BYTE: beat 0 = data[24:31] @ addr.
  - HALF: beat 0 = data[16:23] @ addr; beat 1 = data[24:31] @ addr+1.
  - WORD: beats 0..3 = data[0:7], [8:15], [16:23], [24:31] @ addr..addr+3.
- SEND:
  - req_ready=0; mem_valid=1.
  - mem_addr/mem_byte stay stable until mem_ready=1 (a beat completes when mem_valid and mem_ready are both high at an edge).
  - After each completed beat, increment the beat index; mem_addr = captured addr + index, wrapping modulo 2^ADDR_W.
  - After the last beat completes: mem_valid=0 and go to FINISH.
  - mem_ready held low means the unit waits indefinitely; there is no timeout.
- FINISH:
  - done=1 for exactly one cycle; req_ready=0.
  - Next state is IDLE.
- Latency:
  - Accept at edge N; first mem_valid=1 in cycle N+1.
  - With mem_ready tied high, a k-byte store asserts done in cycle N+1+k.
  - Next accept is possible at the edge ending that done cycle + 1.
- mem_ready asserted while mem_valid=0 is ignored.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- err and done never assert in the same cycle.

Decomposition:
- Shared package store_pkg holds:
  - size codes SIZE_BYTE/SIZE_HALF/SIZE_WORD;
  - state encoding (IDLE, SEND, FINISH);
  - function beats_for_size;
  - function misaligned(size, addr_lsbs).
- One sub-module: store_lane_mux.
  - Combinational; inputs captured data, size and beat index [0:1].
  - Output is the selected [0:7] byte.
  - Reused later by the load-side assembler.

Test Plan:
1. Word store: data=32'hA1B2C3D4, addr=0x100, mem_ready=1 -> beats (0x100,A1), (0x101,B2), (0x102,C3), (0x103,D4) in consecutive cycles; done in cycle N+5; err never asserted.
2. Half store with backpressure: data=32'h0000BEEF, addr=0x22, mem_ready low 3 cycles on beat 0 -> beat (0x22,BE) held stable for 4 cycles, then (0x23,EF); single done pulse.
3. Byte store at odd address: data=32'h12345678, addr=0x7 -> single beat (0x7,78); done; req_ready back to 1 the cycle after done.
4. Misaligned and illegal requests: WORD @0x102, HALF @0x5, size=2'b11 @0x0 -> err pulse each; mem_valid stays 0; req_ready stays 1.
5. Reset mid-store: assert rst_n=0 during beat 2 of a WORD store -> mem_valid=0, done=0, req_ready=1 after that edge; a new BYTE store then completes normally.
6. Address wrap: WORD @0xFFFFFFFC -> addresses FC, FD, FE, FF; next request @0x0 completes normally.
